counter_timer_ctrl: RTL



---
 rtl/counter_timer_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl: timer controller for an external 32-bit up/down counter.
// The counter has no enable, so the timer is frozen by holding its load
// input asserted whenever the timer is stopped.
// Optional feature macro: TIMER_CAPTURE_EN (cap_in port, CAPTURE register at
// addr 4, STATUS bit2 'cap').
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | counter held in load, tracking PERIOD; waits for en
// ST_RUN    | counter free-running in direction dir; watches for carry
// ST_RELOAD | one load cycle to restart a periodic timer from PERIOD
module counter_timer_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        irq_ack,
  output logic        cnt_load,
  output logic        cnt_s,
  output logic [31:0] cnt_pdata,
  input  logic [31:0] cnt_val,
  input  logic        cnt_rc
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic        cap_in
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic        dir_q, dir_d;
  logic        periodic_q, periodic_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] period_q, period_d;
  logic        tc_q, tc_d;
  logic        irq_q, irq_d;
  logic        load_prev_q;

  logic ctrl_wr, period_wr, status_wr;
  logic fresh_rc;
  logic expire;
  logic cap_bit;
  logic [31:0] capture_val;

  // Only the low CTRL/STATUS bits carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:4];

  // Bus write decode and carry qualification. Rc is held by the counter
  // during load, so it is stale in the cycle right after any load cycle.
  always_comb begin
    ctrl_wr   = we && (addr == 3'd0);
    period_wr = we && (addr == 3'd1);
    status_wr = we && (addr == 3'd2);
    fresh_rc  = cnt_rc && !load_prev_q;
  end

  // Next-state logic; an abort (en cleared) takes priority over an expiry.
  always_comb begin
    state_d = state_q;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (fresh_rc) begin
          expire  = 1'b1;
          state_d = periodic_q ? ST_RELOAD : ST_IDLE;
        end
      end
      ST_RELOAD: begin
        state_d = en_q ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs to the counter.
  always_comb begin
    cnt_load  = (state_q != ST_RUN);
    cnt_s     = dir_q;
    cnt_pdata = period_q;
    irq       = irq_q;
  end

  // Register-file next values; a CTRL write beats the one-shot en clear,
  // and a tc set beats any clear in the same cycle.
  always_comb begin
    en_d       = en_q;
    dir_d      = dir_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    period_d   = period_q;
    if (ctrl_wr) begin
      en_d       = wdata[0];
      dir_d      = wdata[1];
      periodic_d = wdata[2];
      irq_en_d   = wdata[3];
    end else if (expire && !periodic_q) begin
      en_d = 1'b0;
    end
    if (period_wr) period_d = wdata;
    tc_d  = expire || (tc_q && !(irq_ack || (status_wr && wdata[0])));
    irq_d = tc_d && irq_en_q;
  end

  // Controller state and register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      dir_q       <= 1'b0;
      periodic_q  <= 1'b0;
      irq_en_q    <= 1'b0;
      period_q    <= 32'd0;
      tc_q        <= 1'b0;
      irq_q       <= 1'b0;
      load_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      dir_q       <= dir_d;
      periodic_q  <= periodic_d;
      irq_en_q    <= irq_en_d;
      period_q    <= period_d;
      tc_q        <= tc_d;
      irq_q       <= irq_d;
      load_prev_q <= cnt_load;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic        cap_prev_q;
  logic        cap_q, cap_d;
  logic [31:0] capture_q, capture_d;
  logic        cap_rise;

  // Capture edge detect against the previous sample; set beats clear.
  always_comb begin
    cap_rise  = cap_in && !cap_prev_q;
    cap_d     = cap_rise || (cap_q && !(status_wr && wdata[2]));
    capture_d = cap_rise ? cnt_val : capture_q;
  end

  // Capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_prev_q <= 1'b0;
      cap_q      <= 1'b0;
      capture_q  <= 32'd0;
    end else begin
      cap_prev_q <= cap_in;
      cap_q      <= cap_d;
      capture_q  <= capture_d;
    end
  end

  assign cap_bit     = cap_q;
  assign capture_val = capture_q;
`else
  assign cap_bit     = 1'b0;
  assign capture_val = 32'd0;
`endif

  // Combinational read mux.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      3'd0:    rdata = {28'd0, irq_en_q, periodic_q, dir_q, en_q};
      3'd1:    rdata = period_q;
      3'd2:    rdata = {29'd0, cap_bit, (state_q != ST_IDLE), tc_q};
      3'd3:    rdata = cnt_val;
      3'd4:    rdata = capture_val;
      default: rdata = 32'd0;
    endcase
  end

endmodule
